// File: rtl/axi_master_pkg.sv
// rtl/axi_master_pkg.sv - shared types and AXI constants for axi_burst_master
package axi_master_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    DONE
  } state_e;

  localparam logic [1:0] BURST_INCR    = 2'b01;
  localparam logic [1:0] RESP_OKAY     = 2'b00;
  localparam logic [1:0] RESP_EXOKAY   = 2'b01;
  localparam logic [1:0] RESP_SLVERR   = 2'b10;
  localparam logic [1:0] RESP_DECERR   = 2'b11;
  localparam logic [3:0] CACHE_DEFAULT = 4'b0011;

  function automatic logic [2:0] size_for(input int strb_width);
    return 3'($clog2(strb_width));
  endfunction

endpackage

// File: rtl/axi_burst_master.sv
// rtl/axi_burst_master.sv - single-outstanding AXI4 INCR burst initiator
module axi_burst_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic [ID_WIDTH-1:0]   cmd_id,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [STRB_WIDTH-1:0] wr_strb,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  done_valid,
  output logic                  done_write,
  output logic [1:0]            done_resp,
  output logic [ID_WIDTH-1:0]   done_id,
  output logic                  proto_err,
  output logic [ID_WIDTH-1:0]   m_axi_awid,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awlock,
  output logic [3:0]            m_axi_awcache,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [STRB_WIDTH-1:0] m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [ID_WIDTH-1:0]   m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);
  import axi_master_pkg::*;

  localparam logic [2:0]            AXSIZE    = size_for(STRB_WIDTH);
  localparam int                    LSB       = $clog2(STRB_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'((1 << LSB) - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [7:0]            beat_q, beat_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [ID_WIDTH-1:0]   done_id_q, done_id_d;
  logic                  write_q, write_d;
  logic [1:0]            resp_q, resp_d;
  logic                  proto_err_q, proto_err_d;
  logic                  at_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      beat_q      <= '0;
      id_q        <= '0;
      done_id_q   <= '0;
      write_q     <= 1'b0;
      resp_q      <= RESP_OKAY;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      beat_q      <= beat_d;
      id_q        <= id_d;
      done_id_q   <= done_id_d;
      write_q     <= write_d;
      resp_q      <= resp_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign at_last   = (beat_q == len_q);
  // Gated by rst so the handshake reads as not-ready while reset is held.
  assign cmd_ready = (state_q == IDLE) && !rst;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    len_d         = len_q;
    beat_d        = beat_q;
    id_d          = id_q;
    done_id_d     = done_id_q;
    write_d       = write_q;
    resp_d        = resp_q;
    proto_err_d   = proto_err_q;
    m_axi_awvalid = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    wr_ready      = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_rready  = 1'b0;
    rd_valid      = 1'b0;
    done_valid    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          addr_d    = cmd_addr & ADDR_MASK;
          len_d     = cmd_len;
          id_d      = cmd_id;
          done_id_d = cmd_id;
          write_d   = cmd_write;
          beat_d    = '0;
          resp_d    = RESP_OKAY;
          state_d   = cmd_write ? WR_ADDR : RD_ADDR;
        end
      end
      WR_ADDR: begin
        m_axi_awvalid = 1'b1;
        if (m_axi_awready) state_d = WR_DATA;
      end
      WR_DATA: begin
        m_axi_wvalid = wr_valid;
        wr_ready     = m_axi_wready;
        if (wr_valid && m_axi_wready) begin
          beat_d = beat_q + 8'd1;
          if (at_last) state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) begin
          resp_d    = m_axi_bresp;
          done_id_d = m_axi_bid;
          if (m_axi_bid != id_q) proto_err_d = 1'b1;
          state_d = DONE;
        end
      end
      RD_ADDR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) state_d = RD_DATA;
      end
      RD_DATA: begin
        rd_valid     = m_axi_rvalid;
        m_axi_rready = rd_ready;
        if (m_axi_rvalid && rd_ready) begin
          if (m_axi_rresp > resp_q) resp_d = m_axi_rresp;
          if (m_axi_rid != id_q) proto_err_d = 1'b1;
          // rlast must coincide exactly with the final counted beat.
          if (m_axi_rlast != at_last) proto_err_d = 1'b1;
          beat_d = beat_q + 8'd1;
          if (m_axi_rlast) state_d = DONE;
        end
      end
      DONE: begin
        done_valid = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign m_axi_awid    = id_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = len_q;
  assign m_axi_awsize  = AXSIZE;
  assign m_axi_awburst = BURST_INCR;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = CACHE_DEFAULT;
  assign m_axi_awprot  = 3'b000;

  assign m_axi_arid    = id_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = len_q;
  assign m_axi_arsize  = AXSIZE;
  assign m_axi_arburst = BURST_INCR;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = CACHE_DEFAULT;
  assign m_axi_arprot  = 3'b000;

  assign m_axi_wdata = wr_data;
  assign m_axi_wstrb = wr_strb;
  assign m_axi_wlast = (state_q == WR_DATA) && at_last;

  assign rd_data = m_axi_rdata;
  assign rd_last = (state_q == RD_DATA) && m_axi_rlast;

  assign done_write = (state_q == DONE) && write_q;
  assign done_resp  = resp_q;
  assign done_id    = done_id_q;
  assign proto_err  = proto_err_q;

endmodule

// File: tb/tb_axi_burst_master.sv
// tb/tb_axi_burst_master.sv - directed bench for axi_burst_master with a small AXI RAM model
module tb_axi_burst_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [7:0]  cmd_addr, cmd_len, cmd_id;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        wr_valid, wr_ready;
  logic [31:0] rd_data;
  logic        rd_last, rd_valid, rd_ready;
  logic        done_valid, done_write;
  logic [1:0]  done_resp;
  logic [7:0]  done_id;
  logic        proto_err;
  logic [7:0]  m_axi_awid, m_axi_awaddr, m_axi_awlen;
  logic [2:0]  m_axi_awsize, m_axi_awprot;
  logic [1:0]  m_axi_awburst;
  logic        m_axi_awlock, m_axi_awvalid, m_axi_awready;
  logic [3:0]  m_axi_awcache;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic [7:0]  m_axi_bid;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid, m_axi_bready;
  logic [7:0]  m_axi_arid, m_axi_araddr, m_axi_arlen;
  logic [2:0]  m_axi_arsize, m_axi_arprot;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_arlock, m_axi_arvalid, m_axi_arready;
  logic [3:0]  m_axi_arcache;
  logic [7:0]  m_axi_rid;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int err_beat   = -1;
  int early_last = -1;
  logic [31:0] exp_q[$];
  logic [31:0] wdat_q[$];

  always #5 clk = ~clk;

  axi_burst_master #(
    .DATA_WIDTH(32), .ADDR_WIDTH(8), .STRB_WIDTH(4), .ID_WIDTH(8)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id),
    .wr_data(wr_data), .wr_strb(wr_strb), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .done_valid(done_valid), .done_write(done_write), .done_resp(done_resp),
    .done_id(done_id), .proto_err(proto_err),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
    .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  // 64-word RAM slave; mem[i] resets to A000_0000+i so reads are predictable.
  logic [31:0] mem [0:63];
  int widx, ridx, rcnt, rlen;
  logic r_active;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'hA000_0000 + 32'(i);
      m_axi_bvalid <= 1'b0; m_axi_bid <= '0; m_axi_bresp <= '0;
      m_axi_rvalid <= 1'b0; m_axi_rdata <= '0; m_axi_rresp <= '0;
      m_axi_rlast  <= 1'b0; m_axi_rid <= '0;
      r_active <= 1'b0; widx <= 0; ridx <= 0; rcnt <= 0; rlen <= 0;
    end else begin
      if (m_axi_awvalid && m_axi_awready) begin
        widx      <= int'(m_axi_awaddr >> 2);
        m_axi_bid <= m_axi_awid;
      end
      if (m_axi_wvalid && m_axi_wready) begin
        for (int b = 0; b < 4; b++)
          if (m_axi_wstrb[b]) mem[widx][8*b +: 8] <= m_axi_wdata[8*b +: 8];
        widx <= (widx + 1) % 64;
        if (m_axi_wlast) begin
          m_axi_bvalid <= 1'b1;
          m_axi_bresp  <= 2'b00;
        end
      end
      if (m_axi_bvalid && m_axi_bready) m_axi_bvalid <= 1'b0;
      if (m_axi_arvalid && m_axi_arready) begin
        ridx <= int'(m_axi_araddr >> 2);
        rlen <= int'(m_axi_arlen);
        rcnt <= 0;
        m_axi_rid <= m_axi_arid;
        r_active  <= 1'b1;
      end
      if (m_axi_rvalid && m_axi_rready && m_axi_rlast) begin
        m_axi_rvalid <= 1'b0;
        r_active     <= 1'b0;
      end else if (r_active && (!m_axi_rvalid || m_axi_rready)) begin
        m_axi_rvalid <= 1'b1;
        m_axi_rdata  <= mem[(ridx + rcnt) % 64];
        m_axi_rresp  <= (rcnt == err_beat) ? 2'b10 : 2'b00;
        m_axi_rlast  <= (rcnt == rlen) || (rcnt == early_last);
        rcnt <= rcnt + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic w, input logic [7:0] a, input logic [7:0] l,
                          input logic [7:0] id);
    int n = 0;
    cmd_write = w; cmd_addr = a; cmd_len = l; cmd_id = id; cmd_valid = 1'b1;
    while (!cmd_ready && n < 100) begin tick(); n++; end
    check("cmd_accept", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic write_beats(input int len, input logic [3:0] strb, input bit gap);
    for (int i = 0; i <= len; i++) begin
      int n = 0;
      wr_data = wdat_q[i]; wr_strb = strb; wr_valid = 1'b1;
      while (!wr_ready && n < 100) begin tick(); n++; end
      check("wr_ready_seen", 32'(wr_ready), 32'd1);
      check("wlast", 32'(m_axi_wlast), 32'(i == len));
      tick();
      wr_valid = 1'b0;
      if (gap) tick();
    end
  endtask

  task automatic wait_done(input logic w, input logic [1:0] resp, input logic [7:0] id);
    int n = 0;
    while (!done_valid && n < 100) begin tick(); n++; end
    check("done_seen", 32'(done_valid), 32'd1);
    check("done_write", 32'(done_write), 32'(w));
    check("done_resp", 32'(done_resp), 32'(resp));
    check("done_id", 32'(done_id), 32'(id));
    tick();
    check("done_pulse_end", 32'(done_valid), 32'd0);
    check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
  endtask

  task automatic read_collect(input bit toggle);
    int k = 0;
    int cyc = 0;
    bit seen_last = 0;
    while (!seen_last && cyc < 2000) begin
      rd_ready = toggle ? (cyc % 2 == 1) : 1'b1;
      if (rd_valid && rd_ready) begin
        if (k < exp_q.size()) check("rd_data", rd_data, exp_q[k]);
        check("rd_last", 32'(rd_last), 32'(k == exp_q.size() - 1));
        seen_last = rd_last;
        k++;
      end
      tick();
      cyc++;
    end
    rd_ready = 1'b0;
    check("rd_burst_end", 32'(seen_last), 32'd1);
    check("rd_beats", 32'(k), 32'(exp_q.size()));
  endtask

  task automatic read_burst(input logic [7:0] a, input logic [7:0] l, input logic [7:0] id,
                            input bit toggle, input logic [1:0] resp);
    send_cmd(1'b0, a, l, id);
    read_collect(toggle);
    wait_done(1'b0, resp, id);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0; cmd_id = 0;
    wr_data = 0; wr_strb = 0; wr_valid = 0; rd_ready = 0;
    m_axi_awready = 1'b1; m_axi_wready = 1'b1; m_axi_arready = 1'b1;
    repeat (3) tick();
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_awvalid", 32'(m_axi_awvalid), 32'd0);
    check("rst_arvalid", 32'(m_axi_arvalid), 32'd0);
    check("rst_done_valid", 32'(done_valid), 32'd0);
    check("rst_proto_err", 32'(proto_err), 32'd0);
    check("rst_awaddr", 32'(m_axi_awaddr), 32'd0);
    check("rst_arlen", 32'(m_axi_arlen), 32'd0);
    rst = 1'b0;
    tick();
    check("cmd_ready_after_rst", 32'(cmd_ready), 32'd1);

    // 256-beat read from the reset pattern, wrapping the 64-word RAM
    exp_q.delete();
    for (int k = 0; k < 256; k++) exp_q.push_back(32'hA000_0000 + 32'(k % 64));
    read_burst(8'h00, 8'd255, 8'h01, 1'b0, 2'b00);
    check("len255_proto_err", 32'(proto_err), 32'd0);

    // single-beat write with AW payload and constant fields
    send_cmd(1'b1, 8'h10, 8'd0, 8'h5A);
    check("awvalid_lat1", 32'(m_axi_awvalid), 32'd1);
    check("awaddr", 32'(m_axi_awaddr), 32'h10);
    check("awlen", 32'(m_axi_awlen), 32'd0);
    check("awid", 32'(m_axi_awid), 32'h5A);
    check("awsize", 32'(m_axi_awsize), 32'd2);
    check("awburst", 32'(m_axi_awburst), 32'd1);
    check("awlock", 32'(m_axi_awlock), 32'd0);
    check("awcache", 32'(m_axi_awcache), 32'd3);
    check("awprot", 32'(m_axi_awprot), 32'd0);
    wdat_q = '{32'hDEADBEEF};
    write_beats(0, 4'hF, 1'b0);
    wait_done(1'b1, 2'b00, 8'h5A);
    exp_q = '{32'hDEADBEEF};
    read_burst(8'h10, 8'd0, 8'h5B, 1'b0, 2'b00);

    // 4-beat write with gaps, read back with rd_ready toggling
    wdat_q = '{32'd1, 32'd2, 32'd3, 32'd4};
    send_cmd(1'b1, 8'h40, 8'd3, 8'h21);
    write_beats(3, 4'hF, 1'b1);
    wait_done(1'b1, 2'b00, 8'h21);
    exp_q = '{32'd1, 32'd2, 32'd3, 32'd4};
    read_burst(8'h40, 8'd3, 8'h22, 1'b1, 2'b00);

    // strobed write through an unaligned command address
    wdat_q = '{32'hFFFFFFFF};
    send_cmd(1'b1, 8'h80, 8'd0, 8'h03);
    write_beats(0, 4'hF, 1'b0);
    wait_done(1'b1, 2'b00, 8'h03);
    wdat_q = '{32'hAAAA5555};
    send_cmd(1'b1, 8'h83, 8'd0, 8'h04);
    check("awaddr_aligned", 32'(m_axi_awaddr), 32'h80);
    write_beats(0, 4'b0011, 1'b0);
    wait_done(1'b1, 2'b00, 8'h04);
    exp_q = '{32'hFFFF5555};
    read_burst(8'h80, 8'd0, 8'h05, 1'b0, 2'b00);

    // AW stall: wr_valid already high must not leak onto W
    m_axi_awready = 1'b0;
    wr_data = 32'hCAFEF00D; wr_strb = 4'hF; wr_valid = 1'b1;
    send_cmd(1'b1, 8'h20, 8'd0, 8'h11);
    for (int i = 0; i < 5; i++) begin
      check("aw_stall_valid", 32'(m_axi_awvalid), 32'd1);
      check("aw_stall_addr", 32'(m_axi_awaddr), 32'h20);
      check("aw_stall_id", 32'(m_axi_awid), 32'h11);
      check("aw_stall_wvalid", 32'(m_axi_wvalid), 32'd0);
      check("aw_stall_cmd_ready", 32'(cmd_ready), 32'd0);
      tick();
    end
    m_axi_awready = 1'b1;
    wdat_q = '{32'hCAFEF00D};
    write_beats(0, 4'hF, 1'b0);
    wait_done(1'b1, 2'b00, 8'h11);

    // AR stall
    m_axi_arready = 1'b0;
    send_cmd(1'b0, 8'h20, 8'd0, 8'h12);
    rd_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("ar_stall_valid", 32'(m_axi_arvalid), 32'd1);
      check("ar_stall_addr", 32'(m_axi_araddr), 32'h20);
      check("ar_stall_size", 32'(m_axi_arsize), 32'd2);
      check("ar_stall_cache", 32'(m_axi_arcache), 32'd3);
      check("ar_stall_rready", 32'(m_axi_rready), 32'd0);
      check("ar_stall_rd_valid", 32'(rd_valid), 32'd0);
      check("ar_stall_cmd_ready", 32'(cmd_ready), 32'd0);
      tick();
    end
    m_axi_arready = 1'b1;
    exp_q = '{32'hCAFEF00D};
    read_collect(1'b0);
    wait_done(1'b0, 2'b00, 8'h12);

    // SLVERR and early rlast on the second beat of a 4-beat read
    err_beat = 1; early_last = 1;
    exp_q = '{32'd1, 32'd2};
    read_burst(8'h40, 8'd3, 8'h31, 1'b0, 2'b10);
    check("proto_err_set", 32'(proto_err), 32'd1);
    err_beat = -1; early_last = -1;
    exp_q = '{32'hDEADBEEF};
    read_burst(8'h10, 8'd0, 8'h32, 1'b0, 2'b00);
    check("proto_err_sticky", 32'(proto_err), 32'd1);

    // reset during beat 1 of an 8-beat write
    send_cmd(1'b1, 8'h60, 8'd7, 8'h33);
    wr_data = 32'h11111111; wr_strb = 4'hF; wr_valid = 1'b1;
    for (int n = 0; n < 100 && !wr_ready; n++) tick();
    tick();
    check("mid_burst_wlast", 32'(m_axi_wlast), 32'd0);
    check("mid_burst_wready", 32'(wr_ready), 32'd1);
    rst = 1'b1;
    tick();
    check("mrst_awvalid", 32'(m_axi_awvalid), 32'd0);
    check("mrst_wvalid", 32'(m_axi_wvalid), 32'd0);
    check("mrst_wr_ready", 32'(wr_ready), 32'd0);
    check("mrst_bready", 32'(m_axi_bready), 32'd0);
    check("mrst_rready", 32'(m_axi_rready), 32'd0);
    check("mrst_done_valid", 32'(done_valid), 32'd0);
    check("mrst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("mrst_proto_err", 32'(proto_err), 32'd0);
    rst = 1'b0; wr_valid = 1'b0;
    tick();
    check("mrst_cmd_ready_release", 32'(cmd_ready), 32'd1);
    wdat_q = '{32'h12345678};
    send_cmd(1'b1, 8'h70, 8'd0, 8'h44);
    write_beats(0, 4'hF, 1'b0);
    wait_done(1'b1, 2'b00, 8'h44);
    exp_q = '{32'h12345678};
    read_burst(8'h70, 8'd0, 8'h45, 1'b0, 2'b00);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
